hls_result_streamer: RTL and testbench
======================================

// Module: hls_result_streamer
// PURPOSE
//  Output-side bridge from an HLS ap_fifo write port (din/write/full_n) to a Xillybus
//  FPGA-to-host read stream (rden/empty/data/eof/open). Buffers HLS results in an
//  internal circular FIFO and counts words per frame. After FRAME_WORDS words it drains
//  and raises eof, so the host's read() returns end-of-file. Sits between the HLS
//  HOG/SVM core and the xillybus core; replaces the discrete output FIFO.
// PARAMETERS
//  DATA_W       32  data width of both the HLS and the Xillybus sides
//  ADDR_W       4   FIFO depth = 2**ADDR_W words (16)
//  FRAME_WORDS  64  words per frame before eof; 0 = continuous stream, eof never raised
// PORTS
//  bus_clk       in   1       single clock for all logic
//  rst_n         in   1       synchronous active-low reset
//  user_r_open   in   1       host has device file open; low = flush and return to IDLE
//  hls_din       in   DATA_W  HLS result word
//  hls_write     in   1       HLS write strobe; accepted only when hls_full_n=1
//  hls_full_n    out  1       high = bridge can accept a word this cycle
//  user_r_rden   in   1       Xillybus read enable
//  user_r_empty  out  1       high = no word available
//  user_r_data   out  DATA_W  read data, valid the cycle after an accepted rden
//  user_r_eof    out  1       end-of-file; asserted only together with user_r_empty=1
//  words_out     out  16      words delivered to host this frame (saturates at 16'hFFFF)
//  err_ovf       out  1       sticky: hls_write seen while hls_full_n=0
//  err_unf       out  1       sticky: user_r_rden seen while user_r_empty=1
// BEHAVIOUR
//  Reset (rst_n=0 at a bus_clk edge): state=IDLE, FIFO pointers/count=0, in_cnt=0,
//   words_out=0, user_r_data=0, err_ovf=err_unf=0. Outputs: hls_full_n=0,
//   user_r_empty=1, user_r_eof=0.
//  States (registered):
//   IDLE:   user_r_open=0. Accept nothing; FIFO held flushed. user_r_open=1 -> STREAM.
//   STREAM: hls_full_n = !fifo_full. Each accepted write increments in_cnt (32b).
//           If FRAME_WORDS!=0 and the accepted write makes in_cnt==FRAME_WORDS -> DRAIN.
//   DRAIN:  hls_full_n=0. Host keeps reading. FIFO count reaches 0 -> EOF.
//   EOF:    user_r_empty=1, user_r_eof=1 until user_r_open drops.
//  user_r_open=0 in any state -> IDLE next cycle. Flush pointers/count/in_cnt/words_out.
//   Clear user_r_eof. Errors and user_r_data are kept.
//  Accept conditions:
//   write_ok = hls_write & hls_full_n.
//   read_ok  = user_r_rden & !user_r_empty.
//   hls_full_n and user_r_empty decode only from registered state/count.
//  Latency: a word written at edge N gives user_r_empty=0 after edge N (visible cycle N+1).
//   read_ok at edge M loads user_r_data after edge M. user_r_data holds until the next read_ok.
//  Simultaneous read_ok and write_ok: count unchanged, both pointers advance, no loss.
//   Write into an empty FIFO plus rden in the same cycle: rden ignored (empty was 1), err_unf set.
//  Full: hls_full_n=0 when count==2**ADDR_W. A write while full is dropped and sets err_ovf.
//  Pointers wrap modulo 2**ADDR_W. count is ADDR_W+1 bits.
//  words_out increments on read_ok and saturates. In continuous mode in_cnt wraps freely.
//  Storage may be a distributed RAM with a registered read port. No combinational path
//   from hls_write to user_r_empty, or from user_r_rden to hls_full_n.
// TESTING
//  1 Reset, open=1, HLS writes 0..63 back-to-back, host reads each ready word (FRAME_WORDS=64)
//    -> data 0..63 in order, words_out=64. eof=1 one cycle after last read. hls_full_n=0 from word 64.
//  2 Host idle, HLS writes 20 words -> hls_full_n=0 after the 16th. Words 17-20 held off, no err_ovf.
//    Host then reads all -> 0..19 intact.
//  3 FIFO at count 8, rden and write every cycle for 100 cycles -> count stays 8, sequence intact,
//    no errors.
//  4 Mid-frame (30 words read) drop user_r_open for 1 cycle, reopen -> empty=1, words_out=0,
//    eof=0, new frame of 64 completes.
//  5 FRAME_WORDS=0: stream 1000 words -> eof never asserted, words_out=1000.
//    Force hls_write at full -> err_ovf=1 and stays 1.
//  6 rden while empty -> err_unf=1, user_r_data unchanged. rst_n=0 -> all outputs return to reset values.

Source files
------------

// File: rtl/hls_result_streamer.sv
// Bridge from an HLS ap_fifo write port to a Xillybus host read stream.
// Results pass through a circular FIFO. A frame of FRAME_WORDS words ends in a drain phase, then eof.
module hls_result_streamer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int FRAME_WORDS = 64
) (
    input  logic              bus_clk,
    input  logic              rst_n,
    input  logic              user_r_open,
    input  logic [DATA_W-1:0] hls_din,
    input  logic              hls_write,
    output logic              hls_full_n,
    input  logic              user_r_rden,
    output logic              user_r_empty,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_eof,
    output logic [15:0]       words_out,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_EOF
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [31:0]       in_cnt_reg;
    logic [15:0]       words_out_reg;
    logic [DATA_W-1:0] data_reg;
    logic              err_ovf_reg, err_unf_reg;
    logic              full_n_int, empty_int;
    logic              write_ok, read_ok, frame_done;

    // Handshake flags come only from registered state so no input reaches them combinationally.
    assign full_n_int = (state_reg == S_STREAM) && (count_reg != FULL_CNT);
    assign empty_int  = (count_reg == '0) || (state_reg == S_IDLE) || (state_reg == S_EOF);

    assign write_ok = hls_write & full_n_int;
    assign read_ok  = user_r_rden & ~empty_int;

    generate
        if (FRAME_WORDS == 0) begin : g_continuous
            assign frame_done = 1'b0;
        end else begin : g_framed
            assign frame_done = (in_cnt_reg == 32'(FRAME_WORDS - 1));
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (write_ok && !read_ok) begin
            count_next = count_reg + 1'b1;
        end else if (!write_ok && read_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (user_r_open) state_next = S_STREAM;
            S_STREAM: if (write_ok && frame_done) state_next = S_DRAIN;
            // Move to EOF on the read that empties the FIFO, so eof follows the last word directly.
            S_DRAIN:  if (count_next == '0) state_next = S_EOF;
            S_EOF:    state_next = S_EOF;
            default:  state_next = S_IDLE;
        endcase
        if (!user_r_open) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (write_ok) begin
            mem[wr_ptr_reg] <= hls_din;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            in_cnt_reg    <= '0;
            words_out_reg <= '0;
            data_reg      <= '0;
            err_ovf_reg   <= 1'b0;
            err_unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (hls_write && !full_n_int) begin
                err_ovf_reg <= 1'b1;
            end
            if (user_r_rden && empty_int) begin
                err_unf_reg <= 1'b1;
            end
            if (read_ok) begin
                data_reg <= mem[rd_ptr_reg];
            end
            // A closed device file keeps everything flushed; errors and last data survive.
            if (!user_r_open || state_reg == S_IDLE) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
                in_cnt_reg    <= '0;
                words_out_reg <= '0;
            end else begin
                count_reg <= count_next;
                if (write_ok) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    in_cnt_reg <= in_cnt_reg + 1'b1;
                end
                if (read_ok) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (words_out_reg != 16'hFFFF) begin
                        words_out_reg <= words_out_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign hls_full_n   = full_n_int;
    assign user_r_empty = empty_int;
    assign user_r_eof   = (state_reg == S_EOF);
    assign user_r_data  = data_reg;
    assign words_out    = words_out_reg;
    assign err_ovf      = err_ovf_reg;
    assign err_unf      = err_unf_reg;

endmodule

// File: tb/tb_hls_result_streamer.sv
// Directed bench for hls_result_streamer: a framed instance (64 words) and a continuous instance.
// Stimulus is driven 1 time unit after each rising edge, where outputs are also sampled.
module tb_hls_result_streamer;

    logic        bus_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        open_a = 1'b0;
    logic        open_b = 1'b0;
    logic        sel = 1'b0;
    logic        hls_write = 1'b0;
    logic        user_r_rden = 1'b0;
    logic [31:0] hls_din = '0;

    logic        wr_a, wr_b, rden_a, rden_b;
    logic        full_n_a, full_n_b, empty_a, empty_b, eof_a, eof_b;
    logic        ovf_a, ovf_b, unf_a, unf_b;
    logic [31:0] data_a, data_b;
    logic [15:0] words_a, words_b;

    logic        full_n, empty, eof, ovf, unf;
    logic [31:0] data;
    logic [15:0] words;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit eof_seen = 0;
    bit done;

    always #5 bus_clk = ~bus_clk;

    // sel routes the shared strobes to one instance and picks which outputs are observed.
    assign wr_a   = hls_write & ~sel;
    assign wr_b   = hls_write & sel;
    assign rden_a = user_r_rden & ~sel;
    assign rden_b = user_r_rden & sel;
    assign full_n = sel ? full_n_b : full_n_a;
    assign empty  = sel ? empty_b  : empty_a;
    assign eof    = sel ? eof_b    : eof_a;
    assign ovf    = sel ? ovf_b    : ovf_a;
    assign unf    = sel ? unf_b    : unf_a;
    assign data   = sel ? data_b   : data_a;
    assign words  = sel ? words_b  : words_a;

    hls_result_streamer #(.DATA_W(32), .ADDR_W(4), .FRAME_WORDS(64)) dut_a (
        .bus_clk(bus_clk), .rst_n(rst_n), .user_r_open(open_a),
        .hls_din(hls_din), .hls_write(wr_a), .hls_full_n(full_n_a),
        .user_r_rden(rden_a), .user_r_empty(empty_a), .user_r_data(data_a),
        .user_r_eof(eof_a), .words_out(words_a), .err_ovf(ovf_a), .err_unf(unf_a)
    );

    hls_result_streamer #(.DATA_W(32), .ADDR_W(4), .FRAME_WORDS(0)) dut_b (
        .bus_clk(bus_clk), .rst_n(rst_n), .user_r_open(open_b),
        .hls_din(hls_din), .hls_write(wr_b), .hls_full_n(full_n_b),
        .user_r_rden(rden_b), .user_r_empty(empty_b), .user_r_data(data_b),
        .user_r_eof(eof_b), .words_out(words_b), .err_ovf(ovf_b), .err_unf(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    // HLS writes the sequence wr_cnt.. while full_n allows; host reads while data is ready.
    task automatic run(input int wr_lim, input int rd_lim, input bit rd_en,
                       input int budget, output bit ok);
        int cyc = 0;
        bit pend;
        eof_seen = 0;
        while ((wr_cnt < wr_lim || rd_cnt < rd_lim) && cyc < budget) begin
            hls_write   = (wr_cnt < wr_lim) && full_n;
            hls_din     = 32'(wr_cnt);
            user_r_rden = rd_en && (rd_cnt < rd_lim) && !empty;
            pend        = user_r_rden;
            if (hls_write) wr_cnt++;
            step();
            cyc++;
            if (eof) eof_seen = 1;
            if (pend) begin
                chk("read data", data, 32'(rd_cnt));
                rd_cnt++;
            end
        end
        hls_write   = 1'b0;
        user_r_rden = 1'b0;
        ok = (wr_cnt >= wr_lim) && (rd_cnt >= rd_lim);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " full_n"}, full_n, 0);
        chk({tag, " empty"}, empty, 1);
        chk({tag, " eof"}, eof, 0);
        chk({tag, " words"}, words, 0);
        chk({tag, " data"}, data, 0);
        chk({tag, " ovf"}, ovf, 0);
        chk({tag, " unf"}, unf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk_reset_values("reset");
        $display("reset: full_n=%0b empty=%0b eof=%0b", full_n, empty, eof);

        // T1: one full frame, host reads every ready word
        rst_n = 1'b1;
        open_a = 1'b1;
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(64, 64, 1, 400, done);
        chk("t1 done", done, 1);
        chk("t1 eof", eof, 1);
        chk("t1 empty", empty, 1);
        chk("t1 words", words, 64);
        chk("t1 full_n", full_n, 0);
        chk("t1 unf", unf, 0);
        $display("T1 frame: words_out=%0d eof=%0b", words, eof);

        // T2: host idle while HLS pushes 20 words; only 16 fit
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(20, 0, 0, 30, done);
        chk("t2 accepted", 32'(wr_cnt), 16);
        chk("t2 full_n", full_n, 0);
        chk("t2 empty", empty, 0);
        chk("t2 ovf", ovf, 0);
        run(20, 20, 1, 200, done);
        chk("t2 done", done, 1);
        chk("t2 words", words, 20);
        $display("T2 backpressure: words_out=%0d ovf=%0b", words, ovf);

        // T4: close mid-frame after 30 words, reopen, full frame again
        open_a = 1'b0;
        step();
        open_a = 1'b1;
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(30, 30, 1, 200, done);
        chk("t4 mid words", words, 30);
        open_a = 1'b0;
        step();
        open_a = 1'b1;
        chk("t4 close empty", empty, 1);
        chk("t4 close words", words, 0);
        chk("t4 close eof", eof, 0);
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(64, 64, 1, 400, done);
        chk("t4 done", done, 1);
        chk("t4 eof", eof, 1);
        chk("t4 words", words, 64);
        $display("T4 reopen: words_out=%0d eof=%0b", words, eof);

        // T3: continuous instance, steady count of 8 with read+write each cycle
        sel = 1'b1;
        open_b = 1'b1;
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(8, 0, 0, 50, done);
        chk("t3 prefill", done, 1);
        for (int i = 0; i < 100; i++) begin
            chk("t3 full_n", full_n, 1);
            chk("t3 empty", empty, 0);
            hls_write   = 1'b1;
            hls_din     = 32'(wr_cnt);
            user_r_rden = 1'b1;
            wr_cnt++;
            step();
            chk("t3 data", data, 32'(rd_cnt));
            rd_cnt++;
        end
        hls_write = 1'b0;
        user_r_rden = 1'b0;
        run(108, 108, 1, 50, done);
        chk("t3 drain", done, 1);
        chk("t3 empty after 8", empty, 1);
        chk("t3 words", words, 108);
        chk("t3 ovf", ovf, 0);
        chk("t3 unf", unf, 0);
        $display("T3 steady: words_out=%0d", words);

        // T5: 1000-word continuous stream, then overflow attempt
        open_b = 1'b0;
        step();
        open_b = 1'b1;
        step();
        wr_cnt = 0; rd_cnt = 0;
        run(1000, 1000, 1, 4000, done);
        chk("t5 done", done, 1);
        chk("t5 eof seen", eof_seen, 0);
        chk("t5 eof", eof, 0);
        chk("t5 words", words, 1000);
        run(1016, 1000, 0, 100, done);
        chk("t5 fill", done, 1);
        chk("t5 full_n", full_n, 0);
        chk("t5 ovf before", ovf, 0);
        hls_write = 1'b1;
        step();
        hls_write = 1'b0;
        chk("t5 ovf set", ovf, 1);
        repeat (3) step();
        chk("t5 ovf sticky", ovf, 1);
        chk("t5 words held", words, 1000);
        $display("T5 continuous: words_out=%0d ovf=%0b", words, ovf);

        // T6: underflow on framed instance sitting in EOF, then reset
        sel = 1'b0;
        user_r_rden = 1'b1;
        step();
        user_r_rden = 1'b0;
        chk("t6 unf", unf, 1);
        chk("t6 data held", data, 63);
        rst_n = 1'b0;
        step();
        chk_reset_values("t6 reset a");
        sel = 1'b1;
        chk("t6 reset b ovf", ovf, 0);
        chk("t6 reset b words", words, 0);
        sel = 1'b0;
        rst_n = 1'b1;
        $display("T6 underflow/reset: unf=%0b", unf);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
